fpmul_arbiter: RTL and testbench
================================

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 Parameter: LAT, default 3, clock cycles from the multiplier operand inputs to its result output (shared floatmul pipeline depth).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_x, req0_y  input  32 each  requester 0 IEEE-754 single operands.
REQ-006 req0_ready  output  1  requester 0 operand pair accepted this cycle.
REQ-007 req1_valid, req1_x, req1_y, req1_ready  same as REQ-004 to REQ-006 for requester 1.
REQ-008 mul_x, mul_y  output  32 each  registered operands driven to the shared multiplier.
REQ-009 mul_s  input  32  multiplier product, valid LAT cycles after mul_x/mul_y.
REQ-010 res_data  output  32  product returned to requesters (shared bus).
REQ-011 res0_valid, res1_valid  output  1 each  res_data belongs to requester 0 / 1 this cycle.
REQ-012 busy  output  1  at least one operation in flight.

Function
REQ-013 Handshake: transfer on reqN_valid & reqN_ready in the same cycle; reqN_ready is combinational from both valids and the priority register.
REQ-014 At most one grant per cycle; req0_ready & req1_ready is never 1.
REQ-015 Only one requester valid: that requester is granted.
REQ-016 Both valid: grant the requester not granted last (round-robin); priority register last_gnt updates only on a grant.
REQ-017 Neither valid: no grant; last_gnt, mul_x, mul_y hold.
REQ-018 On grant, mul_x/mul_y load the granted operands at the next edge (issue cycle).
REQ-019 Tag pipeline: LAT+1 entry shift register of {valid, id}; entry 0 loads {grant, granted id} every cycle, shifts one stage per cycle, no stalls.
REQ-020 Result: the final tag stage drives res0_valid = valid & id==0, res1_valid = valid & id==1; res_data = mul_s combinationally.
REQ-021 End-to-end latency: accept at edge T, resNvalid asserted during cycle T+1+LAT, for exactly one cycle per accepted operation.
REQ-022 Results return in issue order; no back-pressure on results: requesters must accept.
REQ-023 Throughput: one operation per cycle sustained; LAT+1 operations in flight maximum; no overflow condition exists.
REQ-024 busy = OR of all tag valid bits.
REQ-025 res0_valid & res1_valid is never 1.
REQ-026 No inspection or modification of operand/result values; special values (zero, inf, NaN) pass through unchanged.

Reset
REQ-027 While reset is high at an edge: all tag valid bits cleared, last_gnt = 1 (requester 0 wins first tie), mul_x = mul_y = 0.
REQ-028 During reset cycles req0_ready = req1_ready = 0; no operand accepted.
REQ-029 Reset mid-operation discards all in-flight operations: no resNvalid for them after reset, busy = 0 the cycle after reset.
REQ-030 First grant possible in the first cycle with reset low.

Verification
REQ-031 Single op: req0 x=0xBFE00000 (-1.75), y=0xBFC00000 (-1.5) accepted at T -> res0_valid=1, res_data=0x40280000 at T+1+LAT only; res1_valid stays 0.
REQ-032 Tie after reset: both valid continuously for 4 cycles -> grants 0,1,0,1; results return in same order with matching ids, busy high throughout.
REQ-033 Back-to-back single requester: req1 valid for 5 cycles -> 5 accepts, 5 consecutive res1_valid pulses, mapped one-to-one to operands in order.
REQ-034 Reset mid-flight: 3 ops issued, reset asserted 1 cycle before the first result -> no resNvalid afterwards, busy=0, next tie grants requester 0.
REQ-035 Idle hold: no valids for 10 cycles after traffic -> readies 0, mul_x/mul_y unchanged, busy falls LAT+1 cycles after last issue.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for one shared pipelined floating-point multiplier.
// A {valid, id} tag pipeline tracks each issued operation so its result goes back to its owner.
module fpmul_arbiter #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        req1_ready,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [31:0] mul_s,
    output logic [31:0] res_data,
    output logic        res0_valid,
    output logic        res1_valid,
    output logic        busy
);

    logic        last_gnt_q, last_gnt_d;
    logic [31:0] mul_x_q, mul_x_d;
    logic [31:0] mul_y_q, mul_y_d;
    logic [LAT:0] tag_v_q, tag_v_d;
    logic [LAT:0] tag_id_q, tag_id_d;
    logic        gnt0, gnt1;

    // Ties go to whoever was not granted last; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                if (last_gnt_q) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        mul_x_d    = mul_x_q;
        mul_y_d    = mul_y_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
            mul_x_d    = req0_x;
            mul_y_d    = req0_y;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
            mul_x_d    = req1_x;
            mul_y_d    = req1_y;
        end
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        tag_v_d[0]  = gnt0 | gnt1;
        tag_id_d[0] = gnt1;
        for (int unsigned i = 1; i <= LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
            mul_x_q    <= '0;
            mul_y_q    <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            mul_x_q    <= mul_x_d;
            mul_y_q    <= mul_y_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign mul_x      = mul_x_q;
    assign mul_y      = mul_y_q;
    assign res_data   = mul_s;
    assign res0_valid = tag_v_q[LAT] & ~tag_id_q[LAT];
    assign res1_valid = tag_v_q[LAT] & tag_id_q[LAT];
    assign busy       = |tag_v_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a LAT-deep multiplier stand-in that
// returns the true product for the reference vector and a fixed tag function otherwise.
module tb_fpmul_arbiter;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic        req0_ready, req1_ready;
    logic [31:0] mul_x, mul_y, mul_s, res_data;
    logic        res0_valid, res1_valid, busy;
    logic [31:0] pipe [LAT];

    int checks = 0;
    int failures = 0;

    fpmul_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .mul_x(mul_x), .mul_y(mul_y), .mul_s(mul_s), .res_data(res_data),
        .res0_valid(res0_valid), .res1_valid(res1_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'hBFE0_0000 && b == 32'hBFC0_0000) return 32'h4028_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    always @(posedge clk) begin
        pipe[0] <= fmul(mul_x, mul_y);
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign mul_s = pipe[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
        end
        step();
        step();
        checks++;
        if ({busy, res0_valid, res1_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {busy, res0_valid, res1_valid});
        end
        checks++;
        if (mul_x !== 32'h0 || mul_y !== 32'h0) begin
            failures++;
            $display("FAIL reset_operands got=%h/%h exp=0/0", mul_x, mul_y);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1;
        req0_x = 32'hBFE0_0000;
        req0_y = 32'hBFC0_0000;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (mul_x !== 32'hBFE0_0000 || mul_y !== 32'hBFC0_0000) begin
            failures++;
            $display("FAIL single_issue got=%h/%h exp=bfe00000/bfc00000", mul_x, mul_y);
        end
        for (int i = 1; i <= int'(LAT) + 3; i++) begin
            checks++;
            if (res0_valid !== (i == int'(LAT) + 1) || res1_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_res cyc=%0d got=%b%b exp=%b0", i, res0_valid,
                         res1_valid, i == int'(LAT) + 1);
            end
            if (i == int'(LAT) + 1) begin
                checks++;
                if (res_data !== 32'h4028_0000) begin
                    failures++;
                    $display("FAIL single_data got=%h exp=40280000", res_data);
                end
            end
            step();
        end
    endtask

    task automatic test_tie();
        int k;
        logic [31:0] exp_d;
        do_reset();
        for (int j = 0; j < 4 + int'(LAT) + 2; j++) begin
            req0_valid = (j < 4);
            req1_valid = (j < 4);
            req0_x = 32'h3F80_0000 + j;
            req0_y = 32'h4040_0000 + j;
            req1_x = 32'h4000_0000 + j;
            req1_y = 32'h40A0_0000 + j;
            #1;
            if (j < 4) begin
                checks++;
                if (req0_ready !== (j % 2 == 0) || req1_ready !== (j % 2 == 1)) begin
                    failures++;
                    $display("FAIL tie_grant cyc=%0d got=%b%b exp=%b%b", j, req0_ready,
                             req1_ready, j % 2 == 0, j % 2 == 1);
                end
            end
            step();
            k = j - int'(LAT);
            exp_d = (k % 2 == 0) ? fmul(32'h3F80_0000 + k, 32'h4040_0000 + k)
                                 : fmul(32'h4000_0000 + k, 32'h40A0_0000 + k);
            checks++;
            if (res0_valid !== (k >= 0 && k < 4 && k % 2 == 0) ||
                res1_valid !== (k >= 0 && k < 4 && k % 2 == 1)) begin
                failures++;
                $display("FAIL tie_res cyc=%0d got=%b%b", j, res0_valid, res1_valid);
            end
            if (k >= 0 && k < 4 && res_data !== exp_d) begin
                failures++;
                $display("FAIL tie_data cyc=%0d got=%h exp=%h", j, res_data, exp_d);
            end
            checks++;
            if (busy !== (j <= 3 + int'(LAT))) begin
                failures++;
                $display("FAIL tie_busy cyc=%0d got=%b exp=%b", j, busy, j <= 3 + int'(LAT));
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [31:0] exp_d;
        for (int j = 0; j < 5 + int'(LAT) + 2; j++) begin
            req1_valid = (j < 5);
            req1_x = 32'h4100_0000 + j;
            req1_y = 32'h3F00_0000 + 3 * j;
            #1;
            if (j < 5) begin
                checks++;
                if ({req0_ready, req1_ready} !== 2'b01) begin
                    failures++;
                    $display("FAIL b2b_ready cyc=%0d got=%b exp=01", j, {req0_ready, req1_ready});
                end
            end
            step();
            k = j - int'(LAT);
            exp_d = fmul(32'h4100_0000 + k, 32'h3F00_0000 + 3 * k);
            checks++;
            if (res1_valid !== (k >= 0 && k < 5) || res0_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_res cyc=%0d got=%b%b", j, res0_valid, res1_valid);
            end
            if (k >= 0 && k < 5 && res_data !== exp_d) begin
                failures++;
                $display("FAIL b2b_data cyc=%0d got=%h exp=%h", j, res_data, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_x = 32'h7F80_0000;
        req0_y = 32'h0000_0000;
        for (int j = 0; j <= int'(LAT); j++) begin
            req0_valid = (j < 3) || (j == int'(LAT));
            req1_valid = (j == int'(LAT));
            reset = (j == int'(LAT));
            #1;
            if (j == int'(LAT)) begin
                checks++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    failures++;
                    $display("FAIL mid_reset_ready got=%b exp=00", {req0_ready, req1_ready});
                end
            end
            step();
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_busy got=%b exp=0", busy);
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if ({res0_valid, res1_valid} !== 2'b00) begin
                failures++;
                $display("FAIL mid_reset_res cyc=%0d got=%b%b exp=00", j, res0_valid, res1_valid);
            end
            step();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL mid_reset_tie got=%b exp=10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_idle();
        req1_valid = 1'b1;
        req1_x = 32'h7FC0_0001;
        req1_y = 32'hFF80_0000;
        step();
        req1_valid = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                failures++;
                $display("FAIL idle_ready cyc=%0d got=%b exp=00", j, {req0_ready, req1_ready});
            end
            step();
            checks++;
            if (mul_x !== 32'h7FC0_0001 || mul_y !== 32'hFF80_0000) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got=%h/%h exp=7fc00001/ff800000", j, mul_x, mul_y);
            end
            checks++;
            if (busy !== (j <= int'(LAT))) begin
                failures++;
                $display("FAIL idle_busy cyc=%0d got=%b exp=%b", j, busy, j <= int'(LAT));
            end
            if (j == int'(LAT)) begin
                checks++;
                if (res1_valid !== 1'b1 || res_data !== fmul(32'h7FC0_0001, 32'hFF80_0000)) begin
                    failures++;
                    $display("FAIL idle_res got=%b/%h exp=1/%h", res1_valid, res_data,
                             fmul(32'h7FC0_0001, 32'hFF80_0000));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
